// File: rtl/pipelined_datapath.sv
// Three-stage issue/execute/writeback integer datapath with operand forwarding,
// load-use stall, synchronous-read data-memory interface and a debug read port.
module pipelined_datapath #(
  parameter int XLEN       = 32,
  parameter int REG_NUMBER = 32,
  parameter int RS_WIDTH   = $clog2(REG_NUMBER),
  parameter int ALU_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RS_WIDTH-1:0]  rs1,
  input  logic [RS_WIDTH-1:0]  rs2,
  input  logic [RS_WIDTH-1:0]  rd,
  input  logic [XLEN-1:0]      imm,
  input  logic [ALU_WIDTH-1:0] alu_ctrl,
  input  logic                 alu_src,
  input  logic                 mem_to_reg,
  input  logic                 reg_write,
  input  logic                 jal,
  input  logic [XLEN-1:0]      link_addr,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 zero,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_result,
  input  logic [RS_WIDTH-1:0]  dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [ALU_WIDTH-1:0] ALU_AND  = ALU_WIDTH'(0);
  localparam logic [ALU_WIDTH-1:0] ALU_OR   = ALU_WIDTH'(1);
  localparam logic [ALU_WIDTH-1:0] ALU_ADD  = ALU_WIDTH'(2);
  localparam logic [ALU_WIDTH-1:0] ALU_SRL  = ALU_WIDTH'(3);
  localparam logic [ALU_WIDTH-1:0] ALU_XOR  = ALU_WIDTH'(4);
  localparam logic [ALU_WIDTH-1:0] ALU_SLL  = ALU_WIDTH'(5);
  localparam logic [ALU_WIDTH-1:0] ALU_SUB  = ALU_WIDTH'(6);
  localparam logic [ALU_WIDTH-1:0] ALU_SLT  = ALU_WIDTH'(7);
  localparam logic [ALU_WIDTH-1:0] ALU_SLTU = ALU_WIDTH'(8);
  localparam logic [ALU_WIDTH-1:0] ALU_SRA  = ALU_WIDTH'(9);

  logic [XLEN-1:0] rf [REG_NUMBER];

  logic                 ex_valid;
  logic [RS_WIDTH-1:0]  ex_rd;
  logic [XLEN-1:0]      ex_src_a;
  logic [XLEN-1:0]      ex_src_b;
  logic [XLEN-1:0]      ex_rs2_val;
  logic [ALU_WIDTH-1:0] ex_alu_ctrl;
  logic                 ex_mem_to_reg;
  logic                 ex_reg_write;
  logic                 ex_jal;
  logic [XLEN-1:0]      ex_link;

  logic                 wb_valid_q;
  logic [RS_WIDTH-1:0]  wb_rd;
  logic [XLEN-1:0]      wb_alu;
  logic                 wb_mem_to_reg;
  logic                 wb_reg_write;
  logic                 wb_jal;
  logic [XLEN-1:0]      wb_link;

  logic [XLEN-1:0] ex_alu;
  logic [SHW-1:0]  shamt;
  logic            ex_fwd_en;
  logic [XLEN-1:0] ex_fwd_val;
  logic            wb_wr_en;
  logic [XLEN-1:0] wb_value;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] src_b;
  logic            load_use;
  logic            issue;

  assign shamt = ex_src_b[SHW-1:0];

  always_comb begin
    ex_alu = '0;
    case (ex_alu_ctrl)
      ALU_AND:  ex_alu = ex_src_a & ex_src_b;
      ALU_OR:   ex_alu = ex_src_a | ex_src_b;
      ALU_ADD:  ex_alu = ex_src_a + ex_src_b;
      ALU_SRL:  ex_alu = ex_src_a >> shamt;
      ALU_XOR:  ex_alu = ex_src_a ^ ex_src_b;
      ALU_SLL:  ex_alu = ex_src_a << shamt;
      ALU_SUB:  ex_alu = ex_src_a - ex_src_b;
      ALU_SLT:  ex_alu = XLEN'($signed(ex_src_a) < $signed(ex_src_b));
      ALU_SLTU: ex_alu = XLEN'(ex_src_a < ex_src_b);
      ALU_SRA:  ex_alu = $unsigned($signed(ex_src_a) >>> shamt);
      default:  ex_alu = '0;
    endcase
  end

  // A load in EX has no data yet, so it is never a forwarding source; the stall covers it.
  assign ex_fwd_en  = ex_valid && (ex_reg_write || ex_jal) && !ex_mem_to_reg && (ex_rd != '0);
  assign ex_fwd_val = ex_jal ? ex_link : ex_alu;

  assign wb_wr_en = wb_valid_q && (wb_reg_write || wb_jal) && (wb_rd != '0);
  assign wb_value = wb_jal ? wb_link : (wb_mem_to_reg ? mem_rdata : wb_alu);

  // EX outranks WB so the youngest producer of a register wins.
  always_comb begin
    if (rs1 == '0)                      src_a = '0;
    else if (ex_fwd_en && ex_rd == rs1) src_a = ex_fwd_val;
    else if (wb_wr_en && wb_rd == rs1)  src_a = wb_value;
    else                                src_a = rf[rs1];
  end

  always_comb begin
    if (rs2 == '0)                      rs2_val = '0;
    else if (ex_fwd_en && ex_rd == rs2) rs2_val = ex_fwd_val;
    else if (wb_wr_en && wb_rd == rs2)  rs2_val = wb_value;
    else                                rs2_val = rf[rs2];
  end

  assign src_b = alu_src ? imm : rs2_val;

  assign load_use = ex_valid && ex_mem_to_reg && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));
  assign in_ready = !reset && !load_use;
  assign issue    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUMBER; i++) rf[i] <= '0;
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_src_a      <= '0;
      ex_src_b      <= '0;
      ex_rs2_val    <= '0;
      ex_alu_ctrl   <= '0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_jal        <= 1'b0;
      ex_link       <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd         <= '0;
      wb_alu        <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_jal        <= 1'b0;
      wb_link       <= '0;
    end else begin
      ex_valid      <= issue;
      ex_rd         <= rd;
      ex_src_a      <= src_a;
      ex_src_b      <= src_b;
      ex_rs2_val    <= rs2_val;
      ex_alu_ctrl   <= alu_ctrl;
      ex_mem_to_reg <= mem_to_reg;
      ex_reg_write  <= reg_write;
      ex_jal        <= jal;
      ex_link       <= link_addr;
      wb_valid_q    <= ex_valid;
      wb_rd         <= ex_rd;
      wb_alu        <= ex_alu;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_reg_write  <= ex_reg_write;
      wb_jal        <= ex_jal;
      wb_link       <= ex_link;
      if (wb_wr_en) rf[wb_rd] <= wb_value;
    end
  end

  assign mem_addr  = reset ? '0 : ex_alu;
  assign mem_wdata = reset ? '0 : ex_rs2_val;
  assign zero      = !reset && ex_valid && (ex_alu == '0);
  assign wb_valid  = !reset && wb_valid_q;
  assign wb_result = reset ? '0 : wb_value;
  assign dbg_data  = (reset || dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: an in-order architectural register model predicts results,
// stalls and register contents for directed and randomized instruction streams.
module tb_pipelined_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0;
  logic [3:0]  alu_ctrl = '0;
  logic        alu_src = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0, jal = 1'b0;
  logic [31:0] link_addr = '0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        zero, wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  pipelined_datapath dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .link_addr(link_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .zero(zero), .wb_valid(wb_valid), .wb_result(wb_result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src, load, regw, jal;
    logic [31:0] link, ldata;
  } instr_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] model_rf [32];
  logic [31:0] exp_q [$];
  int          sched_cyc [8];
  logic [31:0] sched_d [8];
  logic [31:0] obs_mem [256];
  int          obs_wr = 0;
  int          obs_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Load data appears only in the scheduled writeback cycle; noise otherwise.
  always @(negedge clk) begin
    if (sched_cyc[cyc % 8] == cyc) mem_rdata = sched_d[cyc % 8];
    else mem_rdata = $urandom;
  end

  always begin
    @(negedge clk);
    #2;
    if (wb_valid === 1'b1) begin
      obs_mem[obs_wr % 256] = wb_result;
      obs_wr++;
    end
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a >> b[4:0];
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic [31:0] im, input logic src);
    instr_t t;
    t = '{default: '0};
    t.alu = op; t.rs1 = s1; t.rs2 = s2; t.rd = d; t.imm = im; t.src = src; t.regw = 1'b1;
    return t;
  endfunction

  task automatic pop_obs(output logic [31:0] v);
    if (obs_rd == obs_wr) v = 'x;
    else begin
      v = obs_mem[obs_rd % 256];
      obs_rd++;
    end
  endtask

  task automatic sync_queues();
    obs_rd = obs_wr;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  // Presents one instruction, holding it through stalls; updates the model on acceptance.
  task automatic send(input instr_t t, output int stalls, output logic [31:0] alu_exp,
                      output logic [31:0] rs2_exp);
    logic [31:0] a, b, res;
    bit done;
    stalls = 0; done = 0; alu_exp = '0; rs2_exp = '0;
    @(negedge clk);
    in_valid = 1'b1; rs1 = t.rs1; rs2 = t.rs2; rd = t.rd; imm = t.imm; alu_ctrl = t.alu;
    alu_src = t.src; mem_to_reg = t.load; reg_write = t.regw; jal = t.jal; link_addr = t.link;
    for (int tries = 0; tries < 4 && !done; tries++) begin
      #1;
      if (in_ready === 1'b1) begin
        a = model_rf[t.rs1];
        rs2_exp = model_rf[t.rs2];
        b = t.src ? t.imm : rs2_exp;
        alu_exp = ref_alu(t.alu, a, b);
        res = t.jal ? t.link : (t.load ? t.ldata : alu_exp);
        exp_q.push_back(res);
        if (t.load) begin
          sched_cyc[(cyc + 2) % 8] = cyc + 2;
          sched_d[(cyc + 2) % 8] = t.ldata;
        end
        if ((t.regw || t.jal) && t.rd != 0) model_rf[t.rd] = res;
        done = 1;
        @(posedge clk);
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout in_ready stuck low after %0d cycles, required 1", stalls);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; imm = $urandom; alu_ctrl = 4'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b want=0", zero); end
      n_cmp++; if ({mem_addr, mem_wdata, wb_result, dbg_data} !== 128'd0) begin
        n_err++; $display("FAIL reset_outputs got=%h/%h/%h/%h want=0", mem_addr, mem_wdata, wb_result, dbg_data);
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_wb_valid got=%b want=0", wb_valid); end
    for (int r = 1; r < 4; r++) begin
      @(negedge clk); dbg_addr = 5'(r); #1;
      n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL post_reset_reg x%0d got=%h want=0", r, dbg_data); end
    end
    sync_queues();
  endtask

  task automatic test_add_chain();
    int s1, s2; logic [31:0] ae, re, v;
    sync_queues();
    send(mk(4'd2, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1), s1, ae, re);
    send(mk(4'd2, 5'd1, 5'd0, 5'd2, 32'd3, 1'b1), s2, ae, re);
    idle(3);
    n_cmp++; if (s1 + s2 != 0) begin n_err++; $display("FAIL add_chain_stalls got=%0d want=0", s1 + s2); end
    pop_obs(v);
    n_cmp++; if (v !== 32'd5) begin n_err++; $display("FAIL add_chain_wb0 got=%h want=5", v); end
    pop_obs(v);
    n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL add_chain_wb1 got=%h want=8", v); end
    @(negedge clk); dbg_addr = 5'd2; #1;
    n_cmp++; if (dbg_data !== 32'd8) begin n_err++; $display("FAIL add_chain_dbg_x2 got=%h want=8", dbg_data); end
  endtask

  task automatic test_load_use();
    instr_t t; int s1, s2; logic [31:0] ae, re, v;
    sync_queues();
    t = mk(4'd2, 5'd0, 5'd0, 5'd3, 32'h40, 1'b1);
    t.load = 1'b1; t.ldata = 32'hDEADBEEF;
    send(t, s1, ae, re);
    #1;
    n_cmp++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL load_mem_addr got=%h want=40", mem_addr); end
    send(mk(4'd2, 5'd3, 5'd0, 5'd4, 32'd0, 1'b0), s2, ae, re);
    idle(3);
    n_cmp++; if (s1 != 0) begin n_err++; $display("FAIL load_issue_stalls got=%0d want=0", s1); end
    n_cmp++; if (s2 != 1) begin n_err++; $display("FAIL load_use_stalls got=%0d want=1", s2); end
    pop_obs(v);
    n_cmp++; if (v !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_wb got=%h want=deadbeef", v); end
    pop_obs(v);
    n_cmp++; if (v !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_use_wb got=%h want=deadbeef", v); end
    @(negedge clk); dbg_addr = 5'd4; #1;
    n_cmp++; if (dbg_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_use_dbg_x4 got=%h want=deadbeef", dbg_data); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op  [14] = '{4'd2, 4'd2, 4'd6, 4'd7, 4'd8, 4'd2, 4'd9, 4'd5, 4'd3, 4'd4, 4'd1, 4'd0, 4'd12, 4'd6};
    logic [4:0]  ra  [14] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd11, 5'd7, 5'd11, 5'd6, 5'd7, 5'd6, 5'd6, 5'd7};
    logic [4:0]  rb  [14] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7};
    logic [31:0] im  [14] = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0, 32'h80000000, 32'd4, 32'd33,
                              32'd31, 32'd0, 32'h10, 32'hF0, 32'd0, 32'd0};
    logic        src [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex  [14] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h80000000, 32'hF8000000,
                              32'd2, 32'd1, 32'hFFFFFFFE, 32'h11, 32'hF0, 32'd0, 32'd0};
    int s; logic [31:0] ae, re, v;
    sync_queues();
    for (int i = 0; i < 14; i++) begin
      send(mk(op[i], ra[i], rb[i], 5'(6 + i), im[i], src[i]), s, ae, re);
      #1;
      n_cmp++; if (mem_addr !== ex[i]) begin n_err++; $display("FAIL alu_row%0d_mem_addr got=%h want=%h", i, mem_addr, ex[i]); end
      n_cmp++; if (zero !== (ex[i] == 32'd0)) begin n_err++; $display("FAIL alu_row%0d_zero got=%b want=%b", i, zero, ex[i] == 32'd0); end
      n_cmp++; if (mem_wdata !== re) begin n_err++; $display("FAIL alu_row%0d_mem_wdata got=%h want=%h", i, mem_wdata, re); end
    end
    idle(3);
    for (int i = 0; i < 14; i++) begin
      pop_obs(v);
      n_cmp++; if (v !== ex[i]) begin n_err++; $display("FAIL alu_row%0d_wb got=%h want=%h", i, v, ex[i]); end
    end
  endtask

  task automatic test_jal();
    instr_t t; int s; logic [31:0] ae, re, v;
    logic [31:0] want [4] = '{32'h100, 32'h100, 32'h200, 32'd1};
    sync_queues();
    t = '{default: '0}; t.jal = 1'b1; t.rd = 5'd5; t.link = 32'h100;
    send(t, s, ae, re);
    send(mk(4'd2, 5'd5, 5'd0, 5'd20, 32'd0, 1'b1), s, ae, re);
    t.rd = 5'd0; t.link = 32'h200;
    send(t, s, ae, re);
    send(mk(4'd2, 5'd0, 5'd0, 5'd21, 32'd1, 1'b1), s, ae, re);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      pop_obs(v);
      n_cmp++; if (v !== want[i]) begin n_err++; $display("FAIL jal_wb%0d got=%h want=%h", i, v, want[i]); end
    end
    @(negedge clk); dbg_addr = 5'd5; #1;
    n_cmp++; if (dbg_data !== 32'h100) begin n_err++; $display("FAIL jal_dbg_x5 got=%h want=100", dbg_data); end
    @(negedge clk); dbg_addr = 5'd0; #1;
    n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL jal_dbg_x0 got=%h want=0", dbg_data); end
  endtask

  task automatic test_x0();
    int s; logic [31:0] ae, re, v;
    logic [31:0] want [4] = '{32'd7, 32'd0, 32'd7, 32'd0};
    sync_queues();
    send(mk(4'd2, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1), s, ae, re);
    send(mk(4'd2, 5'd0, 5'd0, 5'd22, 32'd0, 1'b0), s, ae, re);
    send(mk(4'd2, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1), s, ae, re);
    idle(1);
    send(mk(4'd2, 5'd0, 5'd0, 5'd23, 32'd0, 1'b1), s, ae, re);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      pop_obs(v);
      n_cmp++; if (v !== want[i]) begin n_err++; $display("FAIL x0_wb%0d got=%h want=%h", i, v, want[i]); end
    end
    @(negedge clk); dbg_addr = 5'd0; #1;
    n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL x0_dbg got=%h want=0", dbg_data); end
  endtask

  task automatic test_random();
    instr_t t; int s, k; logic [31:0] ae, re, v, e;
    logic prev_load; logic [4:0] prev_rd; logic exp_stall;
    idle(2);
    sync_queues();
    prev_load = 1'b0; prev_rd = '0;
    for (int i = 0; i < 60; i++) begin
      t = mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
      k = $urandom_range(0, 9);
      t.load = (k < 3); t.jal = (k == 3); t.regw = (k != 4);
      t.link = $urandom; t.ldata = $urandom;
      exp_stall = prev_load && (prev_rd != 0) && (prev_rd == t.rs1 || prev_rd == t.rs2);
      send(t, s, ae, re);
      n_cmp++; if (s != int'(exp_stall)) begin n_err++; $display("FAIL rand%0d_stalls got=%0d want=%0d", i, s, exp_stall); end
      prev_load = t.load; prev_rd = t.rd;
    end
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_obs(v);
      n_cmp++; if (v !== e) begin n_err++; $display("FAIL rand_wb got=%h want=%h", v, e); end
    end
    n_cmp++; if (obs_rd != obs_wr) begin n_err++; $display("FAIL rand_extra_wb got=%0d extra want=0", obs_wr - obs_rd); end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); dbg_addr = 5'(r); #1;
      n_cmp++; if (dbg_data !== model_rf[r]) begin n_err++; $display("FAIL rand_dbg_x%0d got=%h want=%h", r, dbg_data, model_rf[r]); end
    end
  endtask

  task automatic test_reset_mid();
    int s; logic [31:0] ae, re;
    sync_queues();
    send(mk(4'd2, 5'd0, 5'd0, 5'd24, 32'h55, 1'b1), s, ae, re);
    send(mk(4'd2, 5'd0, 5'd0, 5'd25, 32'h66, 1'b1), s, ae, re);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; dbg_addr = 5'd2;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midreset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if ({wb_valid, zero} !== 2'b00) begin n_err++; $display("FAIL midreset_flags got=%b%b want=00", wb_valid, zero); end
    n_cmp++; if ({mem_addr, mem_wdata, wb_result, dbg_data} !== 128'd0) begin
      n_err++; $display("FAIL midreset_outputs got=%h/%h/%h/%h want=0", mem_addr, mem_wdata, wb_result, dbg_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_after_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL midreset_after_wb_valid got=%b want=0", wb_valid); end
    for (int r = 23; r < 26; r++) begin
      @(negedge clk); dbg_addr = 5'(r); #1;
      n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL midreset_dbg_x%0d got=%h want=0", r, dbg_data); end
    end
    @(negedge clk); dbg_addr = 5'd2; #1;
    n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL midreset_dbg_x2 got=%h want=0", dbg_data); end
    sync_queues();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin sched_cyc[i] = -1; sched_d[i] = '0; end
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    test_reset();
    test_add_chain();
    test_load_use();
    test_alu_ops();
    test_jal();
    test_x0();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not reach the end, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Three-stage (issue / execute / writeback) integer datapath that replaces the single-cycle register-file-plus-ALU datapath in the core. It is parametrised in data width and register count. It adds operand forwarding, load-use stall handshaking, a synchronous-read data-memory interface, a generalised link write and a debug read port. The control unit drives it one instruction per accepted cycle; data memory sits between the execute and writeback stages.

## Interface
- XLEN, 32, data/register width
- REG_NUMBER, 32, architectural registers; register 0 hardwired to zero
- RS_WIDTH, $clog2(REG_NUMBER), register index width
- ALU_WIDTH, 4, ALU opcode width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  control presents an instruction
- in_ready  out  1  datapath accepts it this cycle
- rs1, rs2, rd  in  RS_WIDTH  source and destination indices
- imm  in  XLEN  immediate, already sign-extended
- alu_ctrl  in  ALU_WIDTH  ALU operation
- alu_src  in  1  srcB = imm (1) / rs2 value (0)
- mem_to_reg  in  1  instruction is a load
- reg_write  in  1  write result to rd
- jal  in  1  write link_addr to rd
- link_addr  in  XLEN  return address for jal
- mem_addr  out  XLEN  EX-stage ALU result (address)
- mem_wdata  out  XLEN  EX-stage rs2 value
- mem_rdata  in  XLEN  load data, valid in the cycle after mem_addr
- zero  out  1  EX-stage alu result == 0, qualified by EX valid
- wb_valid  out  1  instruction in writeback this cycle
- wb_result  out  XLEN  value being written back
- dbg_addr  in  RS_WIDTH  debug register index
- dbg_data  out  XLEN  combinational register-file read, no forwarding

## Operation
- **Issue (cycle N):**
  - Instruction accepted when in_valid && in_ready.
  - Operands read combinationally; each source is resolved in this priority:
    - index 0 → 0;
    - EX-stage instruction writing the same rd (non-load) → EX alu result;
    - WB-stage instruction writing the same rd → wb_result;
    - register file.
  - srcA, srcB (per alu_src) and the control bits are registered into EX.
- **Execute (N+1):**
  - ALU combinational on the registered operands; drives mem_addr and zero.
  - ALU result and control bits are registered into WB.
- **Writeback (N+2):**
  - wb_result = jal ? link_addr(registered) : mem_to_reg ? mem_rdata : alu result.
  - The register file is written at the end of N+2 when (reg_write || jal) && rd != 0.
- **ALU:**
  - 0 AND, 1 OR, 2 ADD, 3 SRL, 4 XOR, 5 SLL, 6 SUB, 7 SLT (signed), 8 SLTU, 9 SRA; all others → 0.
  - Shifts use srcB[$clog2(XLEN)-1:0].
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended.
- **Hazards:**
  - Load-use: in_ready = 0 when the EX stage holds a valid load with rd != 0 and rd equal to an incoming rs1, or to rs2 when rs2 is used (alu_src = 0 or store operand). Treat rs2 as always used for simplicity.
  - On a stall, a bubble (valid = 0) enters EX.
  - No other stall sources exist.
- Writes to register 0 are discarded; register 0 is never a forwarding source.

## Timing
- **Reset:**
  - Clears all registers, the EX/WB valid bits and the pipeline registers.
  - During reset: in_ready = 0, wb_valid = 0, zero = 0, mem_addr = 0, mem_wdata = 0, wb_result = 0, dbg_data = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- **Reset mid-operation:** in-flight EX/WB instructions are dropped and no register-file write occurs in the reset cycle.
- **Throughput and latency:**
  - Throughput is 1 instruction per cycle without hazards.
  - Result latency is 2 cycles to wb_valid.
  - Dependent instructions issue back-to-back, except after a load, which costs exactly 1 bubble cycle.
- **Simultaneous events:**
  - WB write and issue read of the same register in one cycle: forwarding supplies the new value.
  - dbg_data shows the old value until the following cycle.
  - When EX and WB both target the same rd, EX wins.
- mem_rdata is sampled only in the WB cycle of a load and ignored otherwise.

## Test plan
- Reset, then ADD x1 = x0 + imm 5 and ADD x2 = x1 + imm 3 back-to-back → no stall, wb_result 5 then 8; dbg_addr 2 → 8.
- Load x3 (mem_rdata = 0xDEADBEEF), then ADD x4 = x3 + x0 → in_ready low exactly one cycle, x4 = 0xDEADBEEF.
- SUB 0 − 1 → 0xFFFFFFFF; SLT(−1, 1) = 1; SLTU(−1, 1) = 0; SRA(0x80000000, 4) = 0xF8000000; SLL(1, 33) = 2; zero asserted only for a zero result.
- jal with rd = 5, link_addr = 0x100 → x5 = 0x100 at N+2; jal with rd = 0 → x0 stays 0 and no forward.
- ADD x0 = x0 + imm 7, then read x0 → 0, including via forwarding.
- Assert reset for 1 cycle with two instructions in flight → no register written, all outputs 0, in_ready low during reset and high the next cycle.
